ngoai_vao_trong: RTL and testbench
==================================

Name: ngoai_vao_trong

Overview:
- LED pattern sequencer for the 8-bit LED bank. It is the outside-to-inside counterpart of the existing centre-outward fill pattern.
- Lights fill from both edges toward the centre, hold, then extinguish from the edges inward.
- Each step is paced by a programmable prescaler. A start/stop handshake lets the board-level controller chain patterns.

Parameters:
- DIV_W, 24, width of the step-period divider input.
- HOLD_STEPS, 2, number of step ticks the full pattern (8'hFF) is held; legal 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserts on 0 regardless of clk; released synchronously by the board reset logic)
- start  in  1  single-cycle request to run one sequence; honoured only in IDLE
- stop  in  1  synchronous abort; priority over start
- loop  in  1  1 = restart FILL automatically after DRAIN completes
- div  in  DIV_W  step period minus 1, in clk cycles; sampled on accepted start
- q  out  8  LED pattern
- busy  out  1  1 while state != IDLE
- done  out  1  one-cycle pulse when a sequence completes normally

Behaviour:
- Reset (reset==0): state=IDLE, q=8'h00, busy=0, done=0, prescaler=0, hold counter=0. Takes effect immediately, including mid-sequence.
- States: IDLE, FILL, HOLD, DRAIN.
- Prescaler: counts 0..div_latched. A step tick fires on the cycle the count equals div_latched, then the count returns to 0. div=0 gives a tick every cycle; the step period is div+1 cycles. The count is cleared on an accepted start and on stop.
- IDLE: q=00. On start=1 and stop=0: latch div, go to FILL. q is unchanged that cycle. The first pattern change occurs div+1 cycles later.
- FILL, per tick:
  - q[7:4] <= (q[7:4]>>1) | 4'b1000
  - q[3:0] <= (q[3:0]<<1) | 4'b0001
  - Sequence: 81, C3, E7, FF.
  - On the tick that produces FF: go to HOLD, hold counter=0.
- HOLD:
  - q stays FF; each tick increments the hold counter.
  - After HOLD_STEPS ticks, go to DRAIN.
  - With HOLD_STEPS=0, the tick producing FF goes directly to DRAIN; the next tick starts the drain.
- DRAIN, per tick:
  - q[7:4] <= q[7:4]>>1
  - q[3:0] <= q[3:0]<<1
  - Sequence: 7E, 3C, 18, 00.
- Completion: on the tick producing 00, done=1 for exactly that registered cycle. Next state is FILL if loop=1 at that cycle, otherwise IDLE. div_latched is retained on loop.
- stop=1 in any non-IDLE state: next cycle q=00, IDLE, no done pulse. stop in IDLE has no effect.
- start while busy: ignored. It does not restart and does not re-latch div.
- Simultaneous start and stop in IDLE: stop wins, stay IDLE.
- Total sequence length: (8+HOLD_STEPS)*(div+1) cycles from accepted start to done.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: NGOAI_VAO_TRONG_DIR_EN.
- Defined:
  - Adds input port dir (1 bit), sampled on accepted start.
  - dir=0: outside-in behaviour as above.
  - dir=1: centre-out fill sequence 18, 3C, 7E, FF, then drain sequence E7, C3, 81, 00.
  - Timing, hold, done and loop are identical to dir=0.
- Undefined: no dir port; outside-in only. Logic is identical to the dir=0 case.

Decomposition:
- Package ngoai_vao_pkg:
  - state enum (IDLE, FILL, HOLD, DRAIN)
  - constants PAT_EMPTY=8'h00, PAT_FULL=8'hFF, NIB_MSB=4'b1000, NIB_LSB=4'b0001
- One sub-module: step_prescaler.
  - Parameter DIV_W.
  - Ports: clk, reset, clr, div, tick.
  - Contains the counter and tick generation.
- The pattern/state logic lives in the top.

Test Plan:
- Reset mid-FILL at q=C3 -> q=00, busy=0, done=0 immediately, without waiting for a clk edge; after release, stays IDLE until start.
- div=0, HOLD_STEPS=2, start pulse, loop=0 -> q on successive cycles: 81, C3, E7, FF, FF, FF, 7E, 3C, 18, 00. done=1 on the cycle q becomes 00; busy falls the next cycle.
- div=3, start pulse -> q=81 exactly 4 cycles after the start cycle; each subsequent change 4 cycles apart; done 40 cycles after start.
- loop=1, div=0 -> after 00/done the next cycle gives 81. Then set loop=0 mid-sequence -> ends in IDLE after the following 00.
- stop asserted when q=E7, with start asserted simultaneously -> q=00, IDLE next cycle, no done. A start 1 cycle later is accepted normally.
- start pulsed again while busy at q=FF -> sequence unaffected. With NGOAI_VAO_TRONG_DIR_EN defined, dir=1, div=0 -> 18, 3C, 7E, FF, FF, FF, E7, C3, 81, 00.

Source files
------------

// File: rtl/ngoai_vao_trong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ngoai_vao_pkg : shared types, constants and step functions for ngoai_vao_trong |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package ngoai_vao_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] PAT_EMPTY = 8'h00;
  localparam logic [7:0] PAT_FULL  = 8'hFF;
  localparam logic [3:0] NIB_MSB   = 4'b1000;
  localparam logic [3:0] NIB_LSB   = 4'b0001;

  // centre=0 lights from the edges inward; centre=1 lights from the middle outward
  function automatic logic [7:0] fill_step(input logic [7:0] cur, input logic centre);
    logic [3:0] hi;
    logic [3:0] lo;
    if (centre) begin
      hi = (cur[7:4] << 1) | NIB_LSB;
      lo = (cur[3:0] >> 1) | NIB_MSB;
    end else begin
      hi = (cur[7:4] >> 1) | NIB_MSB;
      lo = (cur[3:0] << 1) | NIB_LSB;
    end
    return {hi, lo};
  endfunction

  function automatic logic [7:0] drain_step(input logic [7:0] cur, input logic centre);
    logic [3:0] hi;
    logic [3:0] lo;
    if (centre) begin
      hi = cur[7:4] << 1;
      lo = cur[3:0] >> 1;
    end else begin
      hi = cur[7:4] >> 1;
      lo = cur[3:0] << 1;
    end
    return {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ngoai_vao_trong_step_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | step_prescaler : free-running 0..div counter producing one-cycle step ticks |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module step_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = (count == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ngoai_vao_trong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ngoai_vao_trong : outside-in LED fill/hold/drain sequencer, 8-bit bank      |
// | Optional macro NGOAI_VAO_TRONG_DIR_EN adds a dir input (1 = centre-out).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ngoai_vao_trong
  import ngoai_vao_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int HOLD_STEPS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [DIV_W-1:0] div,
`ifdef NGOAI_VAO_TRONG_DIR_EN
  input  logic             dir,
`endif
  output logic [7:0]       q,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] HOLD_LAST = 4'((HOLD_STEPS > 0) ? (HOLD_STEPS - 1) : 0);

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [DIV_W-1:0] div_lat;
  logic             tick;
  logic             accept;
  logic             centre;
  logic [7:0]       fill_next;
  logic [7:0]       drain_next;

  assign accept     = (state == IDLE) && start && !stop;
  assign fill_next  = fill_step(q, centre);
  assign drain_next = drain_step(q, centre);

  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || stop),
    .div   (div_lat),
    .tick  (tick)
  );

`ifdef NGOAI_VAO_TRONG_DIR_EN
  logic dir_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_lat <= 1'b0;
    end else if (accept) begin
      dir_lat <= dir;
    end
  end

  assign centre = dir_lat;
`else
  assign centre = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q        <= PAT_EMPTY;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
      div_lat  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        q <= PAT_EMPTY;
        if (accept) begin
          div_lat <= div;
          state   <= FILL;
          busy    <= 1'b1;
        end
      end else if (stop) begin
        state    <= IDLE;
        q        <= PAT_EMPTY;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end else if (tick) begin
        if (state == FILL) begin
          q <= fill_next;
          if (fill_next == PAT_FULL) begin
            hold_cnt <= '0;
            state    <= (HOLD_STEPS == 0) ? DRAIN : HOLD;
          end
        end else if (state == HOLD) begin
          if (hold_cnt == HOLD_LAST) begin
            state <= DRAIN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else begin
          q <= drain_next;
          if (drain_next == PAT_EMPTY) begin
            done <= 1'b1;
            // div_lat and the prescaler phase carry over into the looped run
            if (loop) begin
              state <= FILL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ngoai_vao_trong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ngoai_vao_trong : scoreboard bench with step-index reference model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ngoai_vao_trong;

  localparam int DIV_W = 24;
  localparam int HOLD  = 2;
  localparam int NSTEP = 8 + HOLD;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             loop  = 1'b0;
  logic [DIV_W-1:0] div   = '0;
`ifdef NGOAI_VAO_TRONG_DIR_EN
  logic             dir   = 1'b0;
`endif
  logic [7:0]       q;
  logic             busy;
  logic             done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got_e;
  exp_t mon_e;

  always #5 clk = ~clk;

  ngoai_vao_trong #(
    .DIV_W      (DIV_W),
    .HOLD_STEPS (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .loop  (loop),
    .div   (div),
`ifdef NGOAI_VAO_TRONG_DIR_EN
    .dir   (dir),
`endif
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  // pattern with k LEDs lit from each edge
  function automatic logic [7:0] edges(input int k);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < k; i++) begin
      p[7-i] = 1'b1;
      p[i]   = 1'b1;
    end
    return p;
  endfunction

  // LED pattern after step s (1..NSTEP) of one sequence
  function automatic logic [7:0] pattern(input int s, input logic centre);
    if (s <= 4) return centre ? ~edges(4 - s) : edges(s);
    if (s <= 4 + HOLD) return 8'hFF;
    return centre ? edges(NSTEP - s) : ~edges(s - 4 - HOLD);
  endfunction

  logic   m_active = 1'b0;
  int     m_idx    = 0;
  longint m_left   = 0;
  longint m_div    = 0;
  logic   m_dir    = 1'b0;
  exp_t   m_out    = '0;

  function automatic logic dir_now();
`ifdef NGOAI_VAO_TRONG_DIR_EN
    return dir;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge reset) begin
    m_active = 1'b0;
    m_idx    = 0;
    m_out    = '0;
  end

  always @(posedge clk) begin
    m_out.done = 1'b0;
    if (!reset) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_out    = '0;
    end else if (!m_active) begin
      m_out.q    = 8'h00;
      m_out.busy = 1'b0;
      if (start && !stop) begin
        m_active   = 1'b1;
        m_div      = longint'(div);
        m_dir      = dir_now();
        m_idx      = 0;
        m_left     = m_div + 1;
        m_out.busy = 1'b1;
      end
    end else if (stop) begin
      m_active   = 1'b0;
      m_out.q    = 8'h00;
      m_out.busy = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left  = m_div + 1;
        m_idx   = m_idx + 1;
        m_out.q = pattern(m_idx, m_dir);
        if (m_idx == NSTEP) begin
          m_out.done = 1'b1;
          m_idx      = 0;
          if (!loop) begin
            m_active   = 1'b0;
            m_out.busy = 1'b0;
          end
        end
      end
    end
    sb.push_back(m_out);
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      got_e = '{q: q, busy: busy, done: done};
      checks++;
      if (got_e !== mon_e) begin
        errors++;
        $display("FAIL out_cycle @%0t: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 $time, q, busy, done, mon_e.q, mon_e.busy, mon_e.done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick_in();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [DIV_W-1:0] d);
    start = 1'b1;
    div   = d;
    tick_in();
    start = 1'b0;
  endtask

  task automatic wait_q(input logic [7:0] v, input int budget, input string name);
    int n;
    n = 0;
    while (q !== v && n < budget) begin
      tick_in();
      n++;
    end
    chk(name, {24'h0, q}, {24'h0, v});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick_in();
      n++;
    end
    chk(name, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) tick_in();
    chk("reset_q", {24'h0, q}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    reset = 1'b1;
    repeat (2) tick_in();

    pulse_start(0);
    wait_done(50, "div0_done");
    tick_in();
    chk("div0_busy_fall", {31'h0, busy}, 32'h0);
    repeat (2) tick_in();

    pulse_start(3);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick_in();
      n++;
    end
    chk("div3_start_to_done", n, 40);
    repeat (3) tick_in();

    loop = 1'b1;
    pulse_start(0);
    wait_done(50, "loop_first_done");
    tick_in();
    chk("loop_restart", {24'h0, q}, 32'h81);
    wait_q(8'hE7, 20, "loop_reach_e7");
    loop = 1'b0;
    wait_done(50, "loop_last_done");
    tick_in();
    chk("loop_end_idle", {31'h0, busy}, 32'h0);
    repeat (2) tick_in();

    pulse_start(1);
    wait_q(8'hE7, 40, "stop_reach_e7");
    start = 1'b1;
    stop  = 1'b1;
    tick_in();
    chk("stop_q", {24'h0, q}, 32'h0);
    chk("stop_busy", {31'h0, busy}, 32'h0);
    stop = 1'b0;
    tick_in();
    start = 1'b0;
    chk("restart_after_stop", {31'h0, busy}, 32'h1);
    wait_done(100, "restart_done");
    repeat (2) tick_in();

    pulse_start(0);
    wait_q(8'hFF, 20, "busy_reach_ff");
    pulse_start(5);
    wait_done(50, "ignored_start_done");
    repeat (2) tick_in();

`ifdef NGOAI_VAO_TRONG_DIR_EN
    dir = 1'b1;
    pulse_start(0);
    dir = 1'b0;
    wait_done(50, "dir1_done");
    repeat (2) tick_in();
`endif

    pulse_start(2);
    wait_q(8'hC3, 40, "rst_reach_c3");
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_q", {24'h0, q}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_done", {31'h0, done}, 32'h0);
    repeat (2) tick_in();
    reset = 1'b1;
    repeat (5) tick_in();
    chk("idle_after_rst", {31'h0, busy}, 32'h0);

    repeat (1500) begin
      tick_in();
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      loop  = ($urandom_range(0, 3) == 0);
      div   = DIV_W'($urandom_range(0, 3));
`ifdef NGOAI_VAO_TRONG_DIR_EN
      dir   = 1'($urandom_range(0, 1));
`endif
    end
    start = 1'b0;
    loop  = 1'b0;
    stop  = 1'b1;
    tick_in();
    stop = 1'b0;
    repeat (3) tick_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
